// File: rtl/retire_trace_fifo_pkg.sv
// rtl/retire_trace_fifo_pkg.sv - types and defaults shared by the retire trace FIFO, its interface and bench
package retire_trace_fifo_pkg;

    localparam int VLEN          = 32;
    localparam int XLEN          = 32;
    localparam int TRANS_ID_BITS = 3;

    localparam int DEF_NR_COMMIT_PORTS = 2;
    localparam int DEF_DEPTH           = 8;
    localparam int DEF_CNT_W           = 16;

    typedef enum logic [3:0] {
        NONE,
        LOAD,
        STORE,
        ALU,
        CTRL_FLOW,
        MULT,
        CSR
    } fu_t;

    typedef struct packed {
        logic [VLEN-1:0]          pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        fu_t                      fu;
    } scoreboard_entry_t;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic            valid;
    } exception_t;

    typedef enum logic [1:0] {
        TRACE_RETIRE,
        TRACE_TRAP
    } trace_kind_e;

    typedef struct packed {
        trace_kind_e              kind;
        logic [VLEN-1:0]          pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        fu_t                      fu;
        logic [XLEN-1:0]          cause;
    } trace_entry_t;

    function automatic trace_entry_t make_record(
        input trace_kind_e       kind,
        input scoreboard_entry_t src,
        input fu_t               fu,
        input logic [XLEN-1:0]   cause
    );
        trace_entry_t r;
        r.kind     = kind;
        r.pc       = src.pc;
        r.trans_id = src.trans_id;
        r.fu       = fu;
        r.cause    = cause;
        return r;
    endfunction

endpackage

// File: rtl/retire_trace_fifo_if.sv
// rtl/retire_trace_fifo_if.sv - commit-side capture and trace drain signals of the retire trace FIFO
interface retire_trace_fifo_if #(
    parameter int NR_COMMIT_PORTS = 2,
    parameter int CNT_W           = 16
) ();
    import retire_trace_fifo_pkg::*;

    scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr;
    logic [NR_COMMIT_PORTS-1:0]              commit_ack;
    exception_t                              exception;
    logic                                    clear;
    logic                                    trace_valid;
    logic                                    trace_ready;
    trace_entry_t                            trace;
    logic                                    stall;
    logic                                    overflow;
    logic [CNT_W-1:0]                        dropped_cnt;

    modport master (
        output commit_instr, commit_ack, exception, clear, trace_ready,
        input  trace_valid, trace, stall, overflow, dropped_cnt
    );

    modport slave (
        input  commit_instr, commit_ack, exception, clear, trace_ready,
        output trace_valid, trace, stall, overflow, dropped_cnt
    );

endinterface

// File: rtl/retire_trace_fifo.sv
// rtl/retire_trace_fifo.sv - multi-write single-read FIFO of retire and trap records in program order
module retire_trace_fifo
    import retire_trace_fifo_pkg::*;
#(
    parameter int NR_COMMIT_PORTS = DEF_NR_COMMIT_PORTS,
    parameter int DEPTH           = DEF_DEPTH,
    parameter int CNT_W           = DEF_CNT_W
) (
    input logic                clk_i,
    input logic                rst_i,
    retire_trace_fifo_if.slave tf
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam int              SLOTS   = NR_COMMIT_PORTS + 1;
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]  SLOTS_C = (PTR_W + 1)'(SLOTS);

    trace_entry_t     storage [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             overflow_q;
    logic [CNT_W-1:0] drop_cnt_q;

    trace_entry_t     records [SLOTS];
    logic [SLOTS-1:0] slot_we;
    logic [PTR_W:0]   n_rec;
    logic [PTR_W:0]   free;
    logic [PTR_W:0]   written;
    logic [PTR_W:0]   dropped;
    logic [PTR_W:0]   count_next;
    logic             pop;
    logic [CNT_W:0]   drop_sum;

    // Acked ports are packed into the lowest slots so the oldest retire lands at wr_ptr;
    // a trap always follows the retires of its cycle.
    always_comb begin : build_records
        int unsigned idx;
        idx = 0;
        for (int s = 0; s < SLOTS; s++) begin
            records[s] = '0;
        end
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (tf.commit_ack[i]) begin
                records[idx] = make_record(TRACE_RETIRE, tf.commit_instr[i],
                                           tf.commit_instr[i].fu, '0);
                idx++;
            end
        end
        if (tf.exception.valid) begin
            records[idx] = make_record(TRACE_TRAP, tf.commit_instr[0], NONE, tf.exception.cause);
            idx++;
        end
        n_rec = (PTR_W + 1)'(idx);

        // Space is judged on the registered count only; a same-cycle pop does not help writers.
        free    = DEPTH_C - count;
        written = (n_rec < free) ? n_rec : free;
        dropped = n_rec - written;
        for (int s = 0; s < SLOTS; s++) begin
            slot_we[s] = ((PTR_W + 1)'(s) < written);
        end

        pop        = (count != '0) && tf.trace_ready;
        count_next = count + written - {{PTR_W{1'b0}}, pop};
        drop_sum   = {1'b0, drop_cnt_q} + (CNT_W + 1)'(dropped);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || tf.clear) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            for (int s = 0; s < SLOTS; s++) begin
                if (slot_we[s]) begin
                    storage[wr_ptr + PTR_W'(s)] <= records[s];
                end
            end
            wr_ptr <= wr_ptr + written[PTR_W-1:0];
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            if (dropped != '0) begin
                overflow_q <= 1'b1;
                drop_cnt_q <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            end
        end
    end

    assign tf.trace_valid = (count != '0);
    assign tf.trace       = storage[rd_ptr];
    assign tf.stall       = (free < SLOTS_C);
    assign tf.overflow    = overflow_q;
    assign tf.dropped_cnt = drop_cnt_q;

endmodule
